hazard_logger: RTL
==================

// Module: hazard_logger
// PURPOSE
//  Watches the register-read operands of each instruction leaving ID. Compares them
//  against the destinations of the three older in-flight instructions (EX/MEM/WB).
//  Every RAW dependency found is packed into a flattened hazard_mem vector.
//  Sits directly upstream of the hazard display stage, which decodes hazard_mem slot by slot.
// PARAMETERS
//  DEPTH     13  number of log slots; hazard_mem width = 8*DEPTH+1
//  REG_W     3   register-index width (8 architectural registers)
//  TAG_W     3   instruction sequence tag width (mod-8 program order)
//  SKIP_R0   0   1 = reads/writes of register 0 never generate a hazard
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  id_valid      in   1        instruction present in ID this cycle (0 = bubble)
//  id_tag        in   TAG_W    program-order tag of the ID instruction
//  id_rs1        in   REG_W    source 1 index
//  id_rs2        in   REG_W    source 2 index
//  id_rs_used    in   2        [0]=rs1 read, [1]=rs2 read
//  id_rd         in   REG_W    destination index
//  id_regwrite   in   1        ID instruction writes id_rd
//  log_clear     in   1        synchronous clear of log, count and overflow
//  hazard_mem    out  8*DEPTH+1  packed log (layout below), registered
//  log_count     out  4        slots filled, 0..DEPTH
//  hazard_pulse  out  1        1-cycle pulse: >=1 entry written at this edge
// BEHAVIOUR
//  Slot k layout: [8k+7:8k+5]=consumer tag, [8k+4:8k+2]=producer tag,
//   [8k+1:8k]=distance (1=EX, 2=MEM, 3=WB; 0 = empty slot). Bit [8*DEPTH] = sticky overflow.
//  Empty slots are all-zero; consumer tag != producer tag in every written slot.
//  Shadow pipe: 3 stages sh_ex, sh_mem, sh_wb, each holding {valid, tag, rd, regwrite}.
//   It advances every clk: sh_wb<=sh_mem, sh_mem<=sh_ex, sh_ex<={id_valid, id_tag, id_rd, id_regwrite}.
//   A bubble (id_valid=0) enters as valid=0.
//  Detection is combinational on the current ID inputs vs pre-edge shadow contents.
//   A source matches a stage when that stage is valid and regwrite=1, rd==rs, and the rs_used bit is set.
//   With SKIP_R0=1, rs==0 never matches.
//   Per source, only the nearest match is logged (EX > MEM > WB).
//  At most 2 entries per cycle: rs1 first, then rs2, written into consecutive slots from log_count upward.
//   If rs1==rs2 and both match, only one entry is written.
//  Latency: hazard in ID at cycle n -> visible in hazard_mem/log_count after edge n+1.
//   hazard_pulse is high in that same cycle.
//  Full: if log_count==DEPTH, further hazards are dropped and overflow=1.
//   If one slot remains and two hazards arrive, rs1 is stored, rs2 is dropped, overflow=1.
//   Log contents never shift or wrap.
//  log_clear: zeroes hazard_mem, log_count and overflow on the next edge.
//   Same-cycle hazards are dropped (clear wins). The shadow pipe keeps advancing normally.
//  Reset: hazard_mem=0, log_count=0, hazard_pulse=0, all shadow valid=0.
//   Reset mid-stream discards everything; the first post-reset instruction sees no producers.
//  No combinational path from inputs to any output.
// TESTING
//  T1 tag1 rd=3 regwrite; next cycle tag2 rs1=3 used -> slot0 = {3'd2,3'd1,2'd1}.
//     hazard_mem[7:0]=8'h45, log_count=1, pulse one cycle.
//  T2 tag1 writes r5, two bubbles, tag4 reads rs2=5 -> slot0 = {3'd4,3'd1,2'd3}, bits[7:0]=8'h87.
//     A third bubble instead -> no entry.
//  T3 tag1 and tag2 both write r2; tag3 reads r2 -> one entry, producer tag2, distance 1 (nearest wins).
//  T4 tag1 writes r1, tag2 writes r4; tag3 rs1=4 rs2=1 -> slot0={3,2,1}, slot1={3,1,2}, log_count=2.
//     Same case with rs1=rs2=4 -> one entry only.
//  T5 fill to 12 entries, then a double hazard -> slot12 holds rs1 entry, log_count=13, bit104=1.
//     Later hazards leave hazard_mem unchanged.
//  T6 log_clear asserted with a hazard in the same cycle -> all zero next cycle.
//     rst_n pulsed low mid-stream -> outputs 0 asynchronously, and a dependent read right after release logs nothing.

Source files
------------

// File: rtl/hazard_logger.sv
// rtl/hazard_logger.sv - RAW hazard detector and slot logger for instructions leaving ID
module hazard_logger #(
    parameter int DEPTH   = 13,
    parameter int REG_W   = 3,
    parameter int TAG_W   = 3,
    parameter int SKIP_R0 = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [TAG_W-1:0]   id_tag,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [1:0]         id_rs_used,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_regwrite,
    input  logic               log_clear,
    output logic [8*DEPTH:0]   hazard_mem,
    output logic [3:0]         log_count,
    output logic               hazard_pulse
);

    localparam int SLOT_W = 2*TAG_W + 2;

    // Shadow pipe, index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]       sh_v;
    logic [2:0]       sh_w;
    logic [TAG_W-1:0] sh_tag [3];
    logic [REG_W-1:0] sh_rd  [3];

    logic [SLOT_W-1:0] slot     [DEPTH];
    logic [SLOT_W-1:0] slot_nxt [DEPTH];
    logic              ovf, ovf_nxt;
    logic [3:0]        cnt_nxt;
    logic              pulse_nxt;

    logic [2:0]        stage_ok;
    logic              hit1, hit2, keep2;
    logic [1:0]        d1, d2;
    logic [TAG_W-1:0]  p1, p2;
    logic [SLOT_W-1:0] first_e, second_e;
    logic              full, one_left;

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            stage_ok[s] = id_valid && sh_v[s] && sh_w[s] && (sh_tag[s] != id_tag);
        end
    end

    // Walk WB -> EX so the nearest producer overwrites older matches
    always_comb begin
        hit1 = 1'b0;
        d1   = 2'd0;
        p1   = '0;
        hit2 = 1'b0;
        d2   = 2'd0;
        p2   = '0;
        for (int s = 2; s >= 0; s--) begin
            if (stage_ok[s] && id_rs_used[0] && (sh_rd[s] == id_rs1)
                && !((SKIP_R0 != 0) && (id_rs1 == '0))) begin
                hit1 = 1'b1;
                d1   = 2'(s + 1);
                p1   = sh_tag[s];
            end
            if (stage_ok[s] && id_rs_used[1] && (sh_rd[s] == id_rs2)
                && !((SKIP_R0 != 0) && (id_rs2 == '0))) begin
                hit2 = 1'b1;
                d2   = 2'(s + 1);
                p2   = sh_tag[s];
            end
        end
    end

    // Same register read twice is one dependency, logged once
    assign keep2    = hit2 && !(hit1 && (id_rs1 == id_rs2));
    assign first_e  = hit1 ? {id_tag, p1, d1} : {id_tag, p2, d2};
    assign second_e = {id_tag, p2, d2};
    assign full     = (log_count == 4'(DEPTH));
    assign one_left = (log_count == 4'(DEPTH - 1));

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_nxt[k] = slot[k];
        end
        cnt_nxt   = log_count;
        ovf_nxt   = ovf;
        pulse_nxt = 1'b0;
        if (log_clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_nxt[k] = '0;
            end
            cnt_nxt = 4'd0;
            ovf_nxt = 1'b0;
        end else if (hit1 || keep2) begin
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                pulse_nxt = 1'b1;
                for (int k = 0; k < DEPTH; k++) begin
                    if (4'(k) == log_count) begin
                        slot_nxt[k] = first_e;
                    end
                end
                if (hit1 && keep2) begin
                    if (one_left) begin
                        ovf_nxt = 1'b1;
                        cnt_nxt = log_count + 4'd1;
                    end else begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (4'(k) == log_count + 4'd1) begin
                                slot_nxt[k] = second_e;
                            end
                        end
                        cnt_nxt = log_count + 4'd2;
                    end
                end else begin
                    cnt_nxt = log_count + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_v         <= '0;
            sh_w         <= '0;
            for (int s = 0; s < 3; s++) begin
                sh_tag[s] <= '0;
                sh_rd[s]  <= '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                slot[k] <= '0;
            end
            ovf          <= 1'b0;
            log_count    <= 4'd0;
            hazard_pulse <= 1'b0;
        end else begin
            sh_v      <= {sh_v[1:0], id_valid};
            sh_w      <= {sh_w[1:0], id_regwrite};
            sh_tag[2] <= sh_tag[1];
            sh_tag[1] <= sh_tag[0];
            sh_tag[0] <= id_tag;
            sh_rd[2]  <= sh_rd[1];
            sh_rd[1]  <= sh_rd[0];
            sh_rd[0]  <= id_rd;
            for (int k = 0; k < DEPTH; k++) begin
                slot[k] <= slot_nxt[k];
            end
            ovf          <= ovf_nxt;
            log_count    <= cnt_nxt;
            hazard_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        hazard_mem          = '0;
        hazard_mem[8*DEPTH] = ovf;
        for (int k = 0; k < DEPTH; k++) begin
            hazard_mem[8*k +: 8] = slot[k];
        end
    end

endmodule
